// File: rtl/decrypt_pkg.sv
// Shared constants, state encoding and LFSR step for the program-2 decryption sequencer.
// Pure declarations: no latency, no flow control.
package decrypt_pkg;

    localparam int TAP_N          = 9;
    localparam int DEF_CRYPT_BASE = 64;
    localparam int DEF_OUT_BASE   = 0;
    localparam int DEF_NBYTES     = 64;
    localparam int DEF_PRE_CHECK  = 10;
    localparam int DEF_ADDR_W     = 8;
    localparam int CNT_W          = 8;

    localparam logic [6:0] TAPS [TAP_N] = '{
        7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE_RD,
        ST_PRE_CAP,
        ST_SELECT,
        ST_DEC_RD,
        ST_DEC_WR,
        ST_DONE,
        ST_FAIL
    } state_t;

    function automatic logic [6:0] lfsr7_next(input logic [6:0] s, input logic [6:0] tap);
        return {s[5:0], ^(s & tap)};
    endfunction

endpackage

// File: rtl/decrypt_ctrl_lfsr7.sv
// lfsr7: 7-bit Fibonacci LFSR with synchronous load (priority) and step.
// Latency: new state visible the cycle after load/step; no backpressure.
module lfsr7
    import decrypt_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       load,
    input  logic       step,
    input  logic [6:0] tap,
    input  logic [6:0] seed,
    output logic [6:0] state
);

    logic [6:0] state_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= '0;
        end else if (load) begin
            state_q <= seed;
        end else if (step) begin
            state_q <= lfsr7_next(state_q, tap);
        end
    end

    assign state = state_q;

endmodule

// File: rtl/decrypt_ctrl.sv
// decrypt_ctrl: recovers LFSR tap/seed from the space preamble, then decrypts NBYTES back to memory.
// Latency: Ack 150 cycles after launch (22 on FAIL); memory never stalls, Start high aborts to IDLE.
module decrypt_ctrl
    import decrypt_pkg::*;
#(
    parameter int CRYPT_BASE = DEF_CRYPT_BASE,
    parameter int OUT_BASE   = DEF_OUT_BASE,
    parameter int NBYTES     = DEF_NBYTES,
    parameter int PRE_CHECK  = DEF_PRE_CHECK,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    output logic              Ack,
    output logic              Error,
    output logic [3:0]        PatIdx,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemWrEn,
    output logic [7:0]        MemWrData,
    input  logic [7:0]        MemRdData
);

    state_t            state_q, state_d;
    logic              start_q;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [TAP_N-1:0]  alive_q, alive_d;
    logic [3:0]        patidx_q, patidx_d;
    logic [6:0]        init_q, init_d;
    logic [ADDR_W-1:0] addr_q;

    logic              bank_load, bank_step, dec_load, dec_step;
    logic [6:0]        bank_state [TAP_N];
    logic [6:0]        dec_state;
    logic [6:0]        dec_tap;
    logic [6:0]        rd7;
    logic              rd_unused;

    assign rd7       = MemRdData[6:0];
    assign rd_unused = MemRdData[7];
    assign dec_tap   = (patidx_q < 4'd9) ? TAPS[patidx_q] : 7'h00;

    for (genvar g = 0; g < TAP_N; g++) begin : g_bank
        lfsr7 u_lfsr (
            .Clk   (Clk),
            .Reset (Reset),
            .load  (bank_load),
            .step  (bank_step),
            .tap   (TAPS[g]),
            .seed  (rd7),
            .state (bank_state[g])
        );
    end

    lfsr7 u_dec_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .load  (dec_load),
        .step  (dec_step),
        .tap   (dec_tap),
        .seed  (init_q),
        .state (dec_state)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            start_q  <= 1'b0;
            idx_q    <= '0;
            alive_q  <= '0;
            patidx_q <= '0;
            init_q   <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= Start;
            idx_q    <= idx_d;
            alive_q  <= alive_d;
            patidx_q <= patidx_d;
            init_q   <= init_d;
            addr_q   <= MemAddr;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        alive_d   = alive_q;
        patidx_d  = patidx_q;
        init_d    = init_q;
        bank_load = 1'b0;
        bank_step = 1'b0;
        dec_load  = 1'b0;
        dec_step  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_q && !Start) begin
                    state_d = ST_PRE_RD;
                    idx_d   = '0;
                end
            end
            ST_PRE_RD: state_d = ST_PRE_CAP;
            ST_PRE_CAP: begin
                if (idx_q == '0) begin
                    bank_load = 1'b1;
                    alive_d   = '1;
                    init_d    = rd7;
                end else begin
                    // Compare against the post-step value so the kill lands with the step.
                    bank_step = 1'b1;
                    for (int p = 0; p < TAP_N; p++) begin
                        if (lfsr7_next(bank_state[p], TAPS[p]) != rd7) alive_d[p] = 1'b0;
                    end
                end
                if (idx_q == CNT_W'(PRE_CHECK - 1)) begin
                    state_d = ST_SELECT;
                    idx_d   = '0;
                end else begin
                    state_d = ST_PRE_RD;
                    idx_d   = idx_q + 1'b1;
                end
            end
            ST_SELECT: begin
                idx_d = '0;
                if (alive_q == '0 || init_q == '0) begin
                    state_d = ST_FAIL;
                end else begin
                    state_d  = ST_DEC_RD;
                    dec_load = 1'b1;
                    for (int p = TAP_N - 1; p >= 0; p--) begin
                        if (alive_q[p]) patidx_d = 4'(p);
                    end
                end
            end
            ST_DEC_RD: state_d = ST_DEC_WR;
            ST_DEC_WR: begin
                dec_step = 1'b1;
                if (idx_q == CNT_W'(NBYTES - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DEC_RD;
                    idx_d   = idx_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_DONE;
            ST_FAIL: state_d = ST_FAIL;
            default: state_d = ST_IDLE;
        endcase
        if (Start) state_d = ST_IDLE;
    end

    always_comb begin
        MemAddr = addr_q;
        case (state_q)
            ST_PRE_RD, ST_DEC_RD: MemAddr = ADDR_W'(CRYPT_BASE + int'(idx_q));
            ST_DEC_WR:            MemAddr = ADDR_W'(OUT_BASE + int'(idx_q));
            default:              MemAddr = addr_q;
        endcase
    end

    assign MemWrEn   = (state_q == ST_DEC_WR) && !Start;
    assign MemWrData = MemWrEn ? {1'b0, rd7 ^ dec_state} : 8'h00;
    assign Ack       = (state_q == ST_DONE) || (state_q == ST_FAIL);
    assign Error     = (state_q == ST_FAIL);
    assign PatIdx    = patidx_q;

endmodule
